// File: rtl/rtc_clk_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50 %-duty clk_out
// and a one-cycle tick, with run-time divisor writes applied at the next period boundary.
module rtc_clk_divider_multi #(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 23,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIVS = {23'd5000000, 23'd2000},
  parameter int                      SEL_W    = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              wr_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic w_wr_ok;
  logic r_wr_err;

  assign w_wr_ok = div_we && (32'(div_sel) < 32'(NUM_CH)) && (div_val >= TWO);

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register regardless of block order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_wr_err <= 1'b0;
    else        r_wr_err <= div_we && !w_wr_ok;
  end

  assign wr_err = r_wr_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DEF_D = DEF_DIVS[i*CNT_W +: CNT_W];

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pv;
    logic             r_clk;
    logic             r_tick;
    logic             w_hit;
    logic             w_wrap;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W:0]   w_high;

    assign w_hit     = w_wr_ok && (32'(div_sel) == 32'(i));
    assign w_wrap    = (r_cnt == r_div - ONE) || sync_clr;
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    // High-phase length ceil(D/2); the extra bit keeps cnt+1 from overflowing.
    assign w_high    = {1'b0, r_div} - {2'b00, r_div[CNT_W-1:1]};

    // NOTE: the pending divisor is reset along with the live state; it is only a few
    // flops per channel and keeps every register at a known value out of reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= DEF_D;
        r_pend <= DEF_D;
        r_cnt  <= DEF_D - ONE;
        r_pv   <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (!ch_en[i]) begin
        // Parked just before a wrap, so the first enabled edge starts a fresh period.
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
        if (w_hit) begin
          r_div <= div_val;
          r_cnt <= div_val - ONE;
          r_pv  <= 1'b0;
        end else begin
          r_cnt <= r_div - ONE;
        end
      end else begin
        r_tick <= w_wrap;
        if (w_wrap) begin
          r_cnt <= '0;
          r_clk <= 1'b1;
          if (w_hit) begin
            r_div <= div_val;
            r_pv  <= 1'b0;
          end else if (r_pv) begin
            r_div <= r_pend;
            r_pv  <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + ONE;
          r_clk <= (w_cnt_inc < w_high);
          if (w_hit) begin
            r_pend <= div_val;
            r_pv   <= 1'b1;
          end
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule

// File: tb/tb_rtc_clk_divider_multi.sv
// Directed bench for rtc_clk_divider_multi: a period-timestamp model checked every cycle,
// plus hand-computed waveform expectations for each scenario.
module tb_rtc_clk_divider_multi;

  localparam int                      NUM_CH   = 2;
  localparam int                      CNT_W    = 23;
  localparam int                      SEL_W    = 2;
  localparam logic [NUM_CH*CNT_W-1:0] DEF_DIVS = {23'd12, 23'd20};

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NUM_CH-1:0] ch_en   = '0;
  logic              sync_clr = 1'b0;
  logic              div_we  = 1'b0;
  logic [SEL_W-1:0]  div_sel = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              wr_err;

  int n_vec  = 0;
  int n_miss = 0;

  rtc_clk_divider_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIVS(DEF_DIVS),
    .SEL_W   (SEL_W)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .sync_clr(sync_clr),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .wr_err  (wr_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each channel remembers the cycle its current period began; the period ends
  // once D cycles have elapsed, and clk_out is high for the first D - floor(D/2) of them.
  int unsigned       cyc;
  int unsigned       m_div   [NUM_CH];
  int unsigned       m_pend  [NUM_CH];
  int unsigned       m_start [NUM_CH];
  bit                m_pv    [NUM_CH];
  bit                m_parked[NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_tick;
  logic              m_err;

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]    = 32'(DEF_DIVS[c*CNT_W +: CNT_W]);
      m_pend[c]   = 0;
      m_start[c]  = 0;
      m_pv[c]     = 1'b0;
      m_parked[c] = 1'b1;
    end
    m_clk  = '0;
    m_tick = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    bit ok;
    bit hit;
    bit wrap;
    ok    = div_we && (int'(div_sel) < NUM_CH) && (int'(div_val) >= 2);
    m_err = div_we && !ok;
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      hit = ok && (int'(div_sel) == c);
      if (!ch_en[c]) begin
        m_parked[c] = 1'b1;
        m_clk[c]    = 1'b0;
        m_tick[c]   = 1'b0;
        if (hit) begin
          m_div[c] = int'(div_val);
          m_pv[c]  = 1'b0;
        end
      end else begin
        wrap = m_parked[c] || sync_clr || (cyc - m_start[c] >= m_div[c]);
        if (wrap) begin
          m_start[c]  = cyc;
          m_parked[c] = 1'b0;
          if (hit) begin
            m_div[c] = int'(div_val);
            m_pv[c]  = 1'b0;
          end else if (m_pv[c]) begin
            m_div[c] = m_pend[c];
            m_pv[c]  = 1'b0;
          end
        end else if (hit) begin
          m_pend[c] = int'(div_val);
          m_pv[c]   = 1'b1;
        end
        m_tick[c] = wrap;
        m_clk[c]  = (cyc - m_start[c]) < (m_div[c] - m_div[c] / 2);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      check("cycle", 32'({clk_out, tick, wr_err}), 32'({m_clk, m_tick, m_err}));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  logic [9:0] pat_clk;
  logic [9:0] pat_tick;
  int         cnt_tick;
  bit         found;

  initial begin
    // Defaults out of reset: ch0 D=20 (10 high / 10 low), ch1 D=12 (6 high / 6 low).
    ch_en = 2'b11;
    edges(2);
    check("reset_out", 32'({clk_out, tick, wr_err}), 32'd0);
    rst_n = 1'b1;
    edges(1);
    check("first_edge_clk", 32'(clk_out), 32'(2'b11));
    check("first_edge_tick", 32'(tick), 32'(2'b11));
    edges(9);
    check("edge10_clk", 32'(clk_out), 32'(2'b01));
    check("edge10_tick", 32'(tick), 32'(2'b00));
    edges(1);
    check("edge11_clk", 32'(clk_out), 32'(2'b00));
    edges(2);
    check("ch1_period_tick", 32'(tick), 32'(2'b10));
    edges(8);
    check("ch0_period_tick", 32'(tick), 32'(2'b01));
    check("ch0_period_clk", 32'(clk_out), 32'(2'b01));

    // Runtime write D=5 to ch0 four cycles into its period: old 20-cycle period completes.
    edges(3);
    div_we = 1'b1; div_sel = 2'd0; div_val = 23'd5;
    edges(1);
    div_we = 1'b0;
    check("good_wr_err", 32'(wr_err), 32'd0);
    edges(15);
    check("old_period_tail", 32'({clk_out[0], tick[0]}), 32'(2'b00));
    for (int k = 0; k < 10; k++) begin
      edges(1);
      pat_clk  = {pat_clk[8:0], clk_out[0]};
      pat_tick = {pat_tick[8:0], tick[0]};
    end
    check("d5_clk_pattern", 32'(pat_clk), 32'(10'b1110011100));
    check("d5_tick_pattern", 32'(pat_tick), 32'(10'b1000010000));

    // Rejected writes: divisor below 2, then a channel index past the last channel.
    div_we = 1'b1; div_sel = 2'd0; div_val = 23'd1;
    edges(1);
    div_we = 1'b0;
    check("bad_val_err", 32'(wr_err), 32'd1);
    edges(1);
    check("err_one_cycle", 32'(wr_err), 32'd0);
    div_we = 1'b1; div_sel = 2'd2; div_val = 23'd9;
    edges(1);
    div_we = 1'b0;
    check("bad_sel_err", 32'(wr_err), 32'd1);
    cnt_tick = 0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      cnt_tick += int'(tick[0]);
    end
    check("d5_kept_ticks", 32'(cnt_tick), 32'd2);

    // Drop ch0 in the middle of its high phase, write D=4 while parked, re-enable.
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      edges(1);
      if (clk_out[0] && !tick[0]) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_miss++;
      $display("FAIL wait_high: ch0 never in mid-high phase within 12 cycles");
    end
    ch_en = 2'b10;
    edges(1);
    check("disable_clk_tick", 32'({clk_out[0], tick[0]}), 32'(2'b00));
    edges(2);
    div_we = 1'b1; div_sel = 2'd0; div_val = 23'd4;
    edges(1);
    div_we = 1'b0;
    ch_en  = 2'b11;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      pat_clk  = {pat_clk[8:0], clk_out[0]};
      pat_tick = {pat_tick[8:0], tick[0]};
    end
    check("reenable_clk", 32'(pat_clk[7:0]), 32'(8'b11001100));
    check("reenable_tick", 32'(pat_tick[7:0]), 32'(8'b10001000));

    // Both channels at D=7, started three cycles apart, then sync_clr aligns them.
    ch_en = 2'b00;
    edges(1);
    div_we = 1'b1; div_sel = 2'd0; div_val = 23'd7;
    edges(1);
    div_sel = 2'd1;
    edges(1);
    div_we = 1'b0;
    ch_en  = 2'b01;
    edges(3);
    ch_en  = 2'b11;
    edges(5);
    check("out_of_phase", 32'(clk_out[0] ^ clk_out[1]), 32'd1);
    sync_clr = 1'b1;
    edges(1);
    sync_clr = 1'b0;
    check("sync_tick", 32'(tick), 32'(2'b11));
    check("sync_clk", 32'(clk_out), 32'(2'b11));
    for (int k = 0; k < 7; k++) begin
      edges(1);
      pat_clk = {pat_clk[8:0], clk_out[0]};
      check("sync_aligned", 32'(clk_out[1]), 32'(clk_out[0]));
    end
    check("d7_clk_pattern", 32'(pat_clk[6:0]), 32'(7'b1110001));
    check("d7_rewrap_tick", 32'(tick), 32'(2'b11));

    // Asynchronous reset between edges while wr_err is high; divisors revert.
    div_we = 1'b1; div_sel = 2'd3; div_val = 23'd9;
    @(posedge sys_clk);
    #1;
    div_we = 1'b0;
    check("pre_reset_err", 32'(wr_err), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'({clk_out, tick, wr_err}), 32'd0);
    edges(2);
    rst_n = 1'b1;
    edges(1);
    check("post_reset_tick", 32'(tick), 32'(2'b11));
    edges(4);
    check("post_reset_defaults", 32'(clk_out), 32'(2'b11));
    edges(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
